// File: rtl/rule_scheduler_if.sv
// rtl/rule_scheduler_if.sv - guard/fire bundle between the rule scheduler and the protocol system
interface rule_scheduler_if #(
  parameter int N_RULES = 4
);
  logic [N_RULES-1:0] io_guard;
  logic               io_mode;
  logic               io_hold;
  logic [N_RULES-1:0] io_en_a;
  logic               io_fired;
  logic               io_deadlock;
  logic [15:0]        io_fire_count;

  // master is the scheduler side; slave is whoever supplies guards and consumes fires
  modport master (
    input  io_guard, io_mode, io_hold,
    output io_en_a, io_fired, io_deadlock, io_fire_count
  );

  modport slave (
    output io_guard, io_mode, io_hold,
    input  io_en_a, io_fired, io_deadlock, io_fire_count
  );
endinterface

// File: rtl/rule_scheduler.sv
// rtl/rule_scheduler.sv - two-phase select/fire rule arbiter with deadlock detect and fire counter
module rule_scheduler #(
  parameter int          N_RULES         = 4,
  parameter int          DEADLOCK_CYCLES = 8,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic             clock,
  input  logic             reset,
  rule_scheduler_if.master bus
);
  localparam int IDX_W   = $clog2(N_RULES);
  localparam int STALL_W = $clog2(DEADLOCK_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(DEADLOCK_CYCLES);
  localparam logic [15:0]        LFSR_MASK   = 16'hB400;

  typedef enum logic [1:0] {
    ST_SELECT   = 2'd0,
    ST_FIRE     = 2'd1,
    ST_DEADLOCK = 2'd2
  } state_t;

  state_t               r_state, w_state_next;
  logic [IDX_W-1:0]     r_ptr, w_ptr_next;
  logic [15:0]          r_lfsr, w_lfsr_next;
  logic [STALL_W-1:0]   r_stall, w_stall_next, w_stall_inc;
  logic [N_RULES-1:0]   r_en_a, w_en_a_next;
  logic                 r_fired, w_fired_next;
  logic                 r_deadlock, w_deadlock_next;
  logic [15:0]          r_fire_count, w_fire_count_next;

  logic [IDX_W-1:0]     w_start, w_idx, w_sel;
  logic                 w_found;

  // Galois right-shift; advances every cycle so random starts stay decorrelated from activity
  assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_MASK : 16'h0000);

  always_comb begin
    w_start = bus.io_mode ? r_lfsr[IDX_W-1:0] : r_ptr;
    w_idx   = '0;
    w_sel   = '0;
    w_found = 1'b0;
    for (int k = 0; k < N_RULES; k++) begin
      w_idx = w_start + IDX_W'(k);
      if (!w_found && bus.io_guard[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_ptr_next        = r_ptr;
    w_stall_next      = r_stall;
    w_stall_inc       = r_stall + STALL_W'(1);
    w_en_a_next       = '0;
    w_fired_next      = 1'b0;
    w_deadlock_next   = r_deadlock;
    w_fire_count_next = r_fire_count;
    case (r_state)
      ST_SELECT: begin
        if (!bus.io_hold) begin
          if (w_found) begin
            w_en_a_next[w_sel] = 1'b1;
            w_fired_next       = 1'b1;
            w_ptr_next         = w_sel + IDX_W'(1);
            w_stall_next       = '0;
            w_state_next       = ST_FIRE;
          end else begin
            w_stall_next = w_stall_inc;
            if (w_stall_inc == STALL_LIMIT) begin
              w_deadlock_next = 1'b1;
              w_state_next    = ST_DEADLOCK;
            end
          end
        end
      end
      ST_FIRE: begin
        if (r_fire_count != 16'hFFFF) begin
          w_fire_count_next = r_fire_count + 16'd1;
        end
        w_state_next = ST_SELECT;
      end
      ST_DEADLOCK: begin
        w_state_next = ST_DEADLOCK;
      end
      default: begin
        w_state_next = ST_SELECT;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_SELECT;
      r_ptr        <= '0;
      r_lfsr       <= LFSR_SEED;
      r_stall      <= '0;
      r_en_a       <= '0;
      r_fired      <= 1'b0;
      r_deadlock   <= 1'b0;
      r_fire_count <= 16'h0000;
    end else begin
      r_state      <= w_state_next;
      r_ptr        <= w_ptr_next;
      r_lfsr       <= w_lfsr_next;
      r_stall      <= w_stall_next;
      r_en_a       <= w_en_a_next;
      r_fired      <= w_fired_next;
      r_deadlock   <= w_deadlock_next;
      r_fire_count <= w_fire_count_next;
    end
  end

  assign bus.io_en_a       = r_en_a;
  assign bus.io_fired      = r_fired;
  assign bus.io_deadlock   = r_deadlock;
  assign bus.io_fire_count = r_fire_count;
endmodule

// File: tb/tb_rule_scheduler.sv
// tb/tb_rule_scheduler.sv - randomized self-checking bench for rule_scheduler
module tb_rule_scheduler;
  localparam int N  = 4;
  localparam int DL = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  rule_scheduler_if #(.N_RULES(N)) bus ();

  rule_scheduler #(
    .N_RULES(N),
    .DEADLOCK_CYCLES(DL),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  // reference model: "busy" means a fire is pending, not an FSM encoding
  logic [3:0]  m_en;
  logic [15:0] m_lfsr;
  int          m_ptr, m_stall, m_count;
  bit          m_dead;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic model_reset();
    m_en = 0; m_lfsr = 16'hACE1; m_ptr = 0; m_stall = 0; m_count = 0; m_dead = 0;
  endtask

  task automatic model_step(input logic [3:0] g, input logic m, input logic h);
    logic [15:0] l0;
    int start, sel;
    l0 = m_lfsr;
    m_lfsr = lfsr_adv(m_lfsr);
    if (m_dead) begin
      m_en = 0;
    end else if (m_en != 0) begin
      m_en = 0;
      if (m_count < 65535) m_count++;
    end else if (!h) begin
      start = m ? int'(l0 % 16'd4) : m_ptr;
      sel = -1;
      for (int k = 0; k < N; k++)
        if (sel < 0 && g[(start + k) % N]) sel = (start + k) % N;
      if (sel >= 0) begin
        m_en = 4'b0001 << sel;
        m_ptr = (sel + 1) % N;
        m_stall = 0;
      end else begin
        m_stall++;
        if (m_stall == DL) m_dead = 1;
      end
    end
  endtask

  task automatic step(input logic [3:0] g, input logic m, input logic h);
    bus.io_guard = g; bus.io_mode = m; bus.io_hold = h;
    @(posedge clock);
    model_step(g, m, h);
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; bus.io_guard = 0; bus.io_mode = 0; bus.io_hold = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.io_en_a !== 4'b0000) begin failures++; $display("FAIL reset_en_a got=%b exp=0000", bus.io_en_a); end
    checks++; if (bus.io_fired !== 1'b0) begin failures++; $display("FAIL reset_fired got=%b exp=0", bus.io_fired); end
    checks++; if (bus.io_deadlock !== 1'b0) begin failures++; $display("FAIL reset_deadlock got=%b exp=0", bus.io_deadlock); end
    checks++; if (bus.io_fire_count !== 16'h0) begin failures++; $display("FAIL reset_count got=%h exp=0000", bus.io_fire_count); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(4'b1111, 1'b0, 1'b0);
      checks++; if (bus.io_en_a !== exp_seq[i]) begin failures++; $display("FAIL rr_en_a[%0d] got=%b exp=%b", i, bus.io_en_a, exp_seq[i]); end
      checks++; if (bus.io_fired !== (exp_seq[i] != 0)) begin failures++; $display("FAIL rr_fired[%0d] got=%b exp=%b", i, bus.io_fired, exp_seq[i] != 0); end
      if (i == 7) begin
        checks++; if (bus.io_fire_count !== 16'd4) begin failures++; $display("FAIL rr_count got=%0d exp=4", bus.io_fire_count); end
      end
    end
  endtask

  task automatic test_wrap_skip();
    do_reset();
    step(4'b0100, 1'b0, 1'b0);
    checks++; if (bus.io_en_a !== 4'b0100) begin failures++; $display("FAIL wrap_first got=%b exp=0100", bus.io_en_a); end
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0101, 1'b0, 1'b0);
    checks++; if (bus.io_en_a !== 4'b0001) begin failures++; $display("FAIL wrap_pick got=%b exp=0001", bus.io_en_a); end
    step(4'b0101, 1'b0, 1'b0);
    step(4'b0101, 1'b0, 1'b0);
    checks++; if (bus.io_en_a !== 4'b0100) begin failures++; $display("FAIL skip_pick got=%b exp=0100", bus.io_en_a); end
  endtask

  task automatic test_deadlock();
    do_reset();
    for (int i = 1; i <= DL; i++) begin
      step(4'b0000, 1'b0, 1'b0);
      checks++; if (bus.io_deadlock !== (i == DL)) begin failures++; $display("FAIL dl_rise[%0d] got=%b exp=%b", i, bus.io_deadlock, i == DL); end
    end
    for (int i = 0; i < 4; i++) begin
      step(4'b1111, 1'b0, 1'b0);
      checks++; if (bus.io_deadlock !== 1'b1 || bus.io_en_a !== 4'b0000) begin
        failures++; $display("FAIL dl_sticky got=%b/%b exp=1/0000", bus.io_deadlock, bus.io_en_a);
      end
    end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.io_deadlock !== 1'b0) begin failures++; $display("FAIL dl_async_clear got=%b exp=0", bus.io_deadlock); end
    do_reset();
  endtask

  task automatic test_hold();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(4'b1111, 1'b0, 1'b1);
      checks++; if (bus.io_en_a !== 4'b0000) begin failures++; $display("FAIL hold_blocks got=%b exp=0000", bus.io_en_a); end
    end
    do_reset();
    repeat (5) step(4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(4'b0000, 1'b0, 1'b1);
      checks++; if (bus.io_deadlock !== 1'b0) begin failures++; $display("FAIL hold_no_dl[%0d] got=%b exp=0", i, bus.io_deadlock); end
    end
    for (int i = 1; i <= 3; i++) begin
      step(4'b0000, 1'b0, 1'b0);
      checks++; if (bus.io_deadlock !== (i == 3)) begin failures++; $display("FAIL hold_resume[%0d] got=%b exp=%b", i, bus.io_deadlock, i == 3); end
    end
  endtask

  task automatic test_random_mode();
    logic [3:0] seen;
    do_reset();
    seen = 0;
    for (int i = 0; i < 64; i++) begin
      step(4'b1111, 1'b1, 1'b0);
      seen |= bus.io_en_a;
      checks++; if (bus.io_en_a !== m_en) begin failures++; $display("FAIL rand_pick[%0d] got=%b exp=%b", i, bus.io_en_a, m_en); end
    end
    checks++; if (seen !== 4'b1111) begin failures++; $display("FAIL rand_coverage got=%b exp=1111", seen); end
    for (int i = 0; i < 16; i++) begin
      step(4'b0010, 1'b1, 1'b0);
      checks++; if (bus.io_en_a !== m_en || (m_en != 0 && bus.io_en_a !== 4'b0010)) begin
        failures++; $display("FAIL rand_single[%0d] got=%b exp=%b", i, bus.io_en_a, m_en);
      end
    end
  endtask

  task automatic test_random_mixed();
    logic [3:0] g;
    logic m, h;
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 0) do_reset();
      g = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      m = 1'($urandom_range(0, 1));
      h = ($urandom_range(0, 5) == 0);
      step(g, m, h);
      checks++; if (bus.io_en_a !== m_en || bus.io_fired !== (m_en != 0) || bus.io_deadlock !== m_dead || bus.io_fire_count !== 16'(m_count)) begin
        failures++;
        $display("FAIL mixed[%0d] got=%b/%b/%b/%0d exp=%b/%b/%b/%0d", i, bus.io_en_a, bus.io_fired, bus.io_deadlock,
                 bus.io_fire_count, m_en, m_en != 0, m_dead, m_count);
      end
    end
  endtask

  task automatic test_reset_mid_fire();
    do_reset();
    step(4'b0001, 1'b0, 1'b0);
    checks++; if (bus.io_en_a !== 4'b0001) begin failures++; $display("FAIL midfire_setup got=%b exp=0001", bus.io_en_a); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.io_en_a !== 4'b0000) begin failures++; $display("FAIL midfire_en_a got=%b exp=0000", bus.io_en_a); end
    checks++; if (bus.io_fire_count !== 16'h0) begin failures++; $display("FAIL midfire_count got=%0d exp=0", bus.io_fire_count); end
    do_reset();
  endtask

  task automatic test_saturation();
    do_reset();
    force dut.r_fire_count = 16'hFFFE;
    #1 release dut.r_fire_count;
    m_count = 16'hFFFE;
    for (int i = 0; i < 4; i++) begin
      step(4'b1111, 1'b0, 1'b0);
      if (i % 2 == 1) begin
        checks++; if (bus.io_fire_count !== 16'hFFFF) begin failures++; $display("FAIL sat_count[%0d] got=%h exp=ffff", i, bus.io_fire_count); end
      end
    end
  endtask

  initial begin
    bus.io_guard = 0; bus.io_mode = 0; bus.io_hold = 0;
    model_reset();
    test_reset();
    test_round_robin();
    test_wrap_skip();
    test_deadlock();
    test_hold();
    test_random_mode();
    test_random_mixed();
    test_reset_mid_fire();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rule_scheduler.md
# rule_scheduler

Upstream stage of the generated protocol `system`: each step it picks one enabled Murphi rule from the guard vector and drives the one-hot `io_en_a` fire enable into `system`. It uses round-robin or LFSR-random arbitration. A two-phase select/fire cycle guarantees that guards are always sampled on settled post-fire state. It also flags a protocol deadlock when no guard holds for a configurable run of cycles, and counts fired rules.

## Interface
- `N_RULES`, 4: number of rules; width of `io_guard` and `io_en_a`; must be a power of two, ≥ 2.
- `DEADLOCK_CYCLES`, 8: consecutive empty SELECT cycles that declare deadlock; ≥ 1.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero.

- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `io_guard`  in  N_RULES  bit i = guard of rule i, evaluated on the current `system` state.
- `io_mode`  in  1  arbitration mode: 0 = round-robin, 1 = pseudo-random start.
- `io_hold`  in  1  suspends selection while high.
- `io_en_a`  out  N_RULES  registered one-hot fire enable to `system`; all-zero when idle.
- `io_fired`  out  1  high in exactly the cycles in which `io_en_a` is nonzero.
- `io_deadlock`  out  1  sticky deadlock flag.
- `io_fire_count`  out  16  number of rules fired, saturating.

## Operation
- **Reset values:**
  - Outputs: `io_en_a` = 0, `io_fired` = 0, `io_deadlock` = 0, `io_fire_count` = 0.
  - Internal: state = SELECT, `ptr` = 0, `lfsr` = `LFSR_SEED`, `stall` = 0.
- **FSM:**
  - **SELECT:** `io_en_a` = 0.
    - `io_hold` = 1: stay in SELECT. `stall` is neither incremented nor cleared.
    - Otherwise, compute `start`: `ptr` when `io_mode` = 0, or `lfsr[log2(N_RULES)-1:0]` when `io_mode` = 1.
    - `sel` = first index i with `io_guard[i]` = 1, scanning from `start` upward and wrapping modulo N_RULES.
    - If a `sel` exists: register `io_en_a` = 1<<`sel`, set `ptr` ← (`sel`+1) mod N_RULES, clear `stall` to 0, go to FIRE.
    - If `io_guard` = 0: `stall` ← `stall`+1. When the incremented value equals `DEADLOCK_CYCLES`, go to DEADLOCK; otherwise stay in SELECT.
  - **FIRE:** `io_en_a` holds the one-hot value for exactly one cycle. `io_fire_count` ← min(count+1, 16'hFFFF). Next state is always SELECT, regardless of `io_hold` and `io_guard`.
  - **DEADLOCK:** `io_deadlock` = 1, `io_en_a` = 0. Terminal; only `reset` exits.
- **LFSR:** 16-bit Galois, mask 16'hB400. Shifts every cycle out of reset, in every state and regardless of `io_hold` and `io_mode`.
- **Mode change:** `io_mode` is sampled only in SELECT and may change any cycle. `ptr` updates in both modes.
- **Boundaries:**
  - Wrap-around: with `start` = N_RULES-1 and only bit 0 guarded, `sel` = 0.
  - Counter saturation: `io_fire_count` holds at 16'hFFFF.
  - Precedence: `io_hold` dominates deadlock detection.
  - Reset asserted mid-FIRE clears `io_en_a` immediately (asynchronously); the in-flight fire is not counted.

## Timing
- `io_en_a`, `io_fired`, `io_deadlock` and `io_fire_count` are registered; none depends combinationally on inputs.
- `io_guard` sampled in SELECT at edge t → `io_en_a` high during cycle t+1 → `system` commits the rule at edge t+1. The next SELECT (cycle t+1→t+2 edge) samples guards of the updated state.
- Maximum throughput: one rule per 2 cycles.
- `io_fire_count` increments at the edge ending the FIRE cycle.
- `io_deadlock` rises at the edge on which the `DEADLOCK_CYCLES`-th consecutive empty, unheld SELECT is evaluated.

## Test plan
- **Round-robin rotation:** reset, `io_mode`=0, `io_guard`=4'b1111 constant → `io_en_a` sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001; `io_fire_count`=4 after 8 cycles.
- **Wrap and skip:** `ptr`=3 (after firing rule 2), `io_guard`=4'b0101 → `io_en_a`=0001, then `ptr`=1 → next pick 0100.
- **Deadlock:** `io_guard`=0, `io_hold`=0, defaults → `io_deadlock` rises after 8 SELECT cycles and stays 1 with `io_en_a`=0 even once `io_guard`=4'b1111. Asserting `reset` clears the flag asynchronously.
- **Hold:** `io_guard`=0 for 5 cycles, `io_hold`=1 for 20 cycles, then `io_hold`=0 → deadlock only after 3 further empty cycles. `io_hold`=1 with guards set → `io_en_a` stays 0.
- **Random mode:** `io_mode`=1, `io_guard`=4'b1111, seed ACE1 → each pick equals the low 2 bits of the reference-model LFSR at the SELECT cycle; all 4 rules appear within 64 cycles. `io_guard`=4'b0010 → always 0010.
- **Reset mid-fire and saturation:** reset asserted during FIRE → `io_en_a`=0 in the same cycle and `io_fire_count`=0. Force count to 16'hFFFE, fire twice → count holds at 16'hFFFF.
